// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the max-pooling job controller:
//   - pool_ctrl_state_t : job controller FSM states
//   - pool_total()      : pixels in one ROW_SIZE x ROW_SIZE input channel
//   - pool_out_total()  : pixels in one pooled output channel
//   - MP_* defaults     : parameter defaults shared with the max_pooling engine
// -----------------------------------------------------------------------------
package pool_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KICK,
      ST_RUN,
      ST_NEXT,
      ST_FIN
   } pool_ctrl_state_t;

   // Engine-side defaults; the controller must agree with the engine on these.
   localparam int MP_ADDR_WIDTH = 6;
   localparam int MP_DATA_WIDTH = 8;
   localparam int MP_ROW_SIZE   = 8;
   localparam int MP_KERNEL_DIM = 2;

   function automatic int pool_total(input int row_size);
      return row_size * row_size;
   endfunction

   function automatic int pool_out_total(input int row_size, input int kernel_dim);
      return (row_size / kernel_dim) * (row_size / kernel_dim);
   endfunction

endpackage

// File: rtl/pool_watchdog.sv
// -----------------------------------------------------------------------------
// pool_watchdog
// Loadable down-counter used to bound the time the engine may spend on one
// channel. Load arms it with a start count; each enabled cycle counts down by
// one and holds at zero. o_expired is high while armed and at zero.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (disarms)
//   i_clr      in   disarm and zero the counter
//   i_load     in   load i_load_val and arm
//   i_load_val in   start count
//   i_en       in   count down this cycle
//   o_expired  out  armed and count has reached zero
// -----------------------------------------------------------------------------
module pool_watchdog #(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_expired
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_armed;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt   <= '0;
         r_armed <= 1'b0;
      end else if (i_load) begin
         r_cnt   <= i_load_val;
         r_armed <= 1'b1;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt   <= r_cnt - 1'b1;
      end
   end

   // Unarmed zero (after reset/clear) must not look like a timeout.
   assign o_expired = r_armed && (r_cnt == '0);

endmodule

// File: rtl/pool_job_ctrl.sv
// -----------------------------------------------------------------------------
// pool_job_ctrl
// Runs one max_pooling engine once per channel over a multi-channel feature
// map stored back to back in the input BRAM, relocating the engine's local
// addresses by a per-channel base. Provides start/busy/done/err, abort and a
// watchdog, and only lets the host read the output BRAM while no job runs.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, num_ch             job request (IDLE only) and channel count
//   abort                     cancel the running job
//   busy, done, err           status: not idle / completion pulse / sticky error
//   eng_start, eng_done       engine kick pulse / engine finished pulse
//   eng_rd_addr               engine local read address
//   eng_wr_en/addr/data       engine local write port
//   in_rd_addr                input BRAM global read address
//   out_wr_en/addr/data       output BRAM global write port
//   host_rd_req/addr          host read-back request
//   host_rd_gnt, out_rd_addr  host grant and output BRAM read address
// -----------------------------------------------------------------------------
module pool_job_ctrl
   import pool_pkg::*;
#(
   parameter int ADDR_WIDTH  = MP_ADDR_WIDTH,
   parameter int GADDR_WIDTH = 10,
   parameter int DATA_WIDTH  = MP_DATA_WIDTH,
   parameter int ROW_SIZE    = MP_ROW_SIZE,
   parameter int KERNEL_DIM  = MP_KERNEL_DIM,
   parameter int MAX_CH      = 16,
   parameter int TIMEOUT     = 1023
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [$clog2(MAX_CH+1)-1:0]  num_ch,
   input  logic                         abort,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic                         eng_start,
   input  logic                         eng_done,
   input  logic [ADDR_WIDTH-1:0]        eng_rd_addr,
   input  logic                         eng_wr_en,
   input  logic [ADDR_WIDTH-1:0]        eng_wr_addr,
   input  logic [DATA_WIDTH-1:0]        eng_wr_data,
   output logic [GADDR_WIDTH-1:0]       in_rd_addr,
   output logic                         out_wr_en,
   output logic [GADDR_WIDTH-1:0]       out_wr_addr,
   output logic [DATA_WIDTH-1:0]        out_wr_data,
   input  logic                         host_rd_req,
   input  logic [GADDR_WIDTH-1:0]       host_rd_addr,
   output logic                         host_rd_gnt,
   output logic [GADDR_WIDTH-1:0]       out_rd_addr
);

   localparam int NCH_W     = $clog2(MAX_CH + 1);
   localparam int WD_W      = $clog2(TIMEOUT + 1);
   localparam int TOTAL     = pool_total(ROW_SIZE);
   localparam int OUT_TOTAL = pool_out_total(ROW_SIZE, KERNEL_DIM);

   localparam logic [GADDR_WIDTH-1:0] L_TOTAL     = GADDR_WIDTH'(TOTAL);
   localparam logic [GADDR_WIDTH-1:0] L_OUT_TOTAL = GADDR_WIDTH'(OUT_TOTAL);
   localparam logic [NCH_W-1:0]       L_MAX_CH    = NCH_W'(MAX_CH);
   // The counter is loaded in KICK and first decrements in the first RUN
   // cycle, so loading TIMEOUT-1 makes it expire on the TIMEOUT-th RUN cycle.
   localparam logic [WD_W-1:0]        WD_LOAD     = WD_W'(TIMEOUT - 1);

   pool_ctrl_state_t        r_state;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_kick;
   logic                    r_err;
   logic [NCH_W-1:0]        r_num_ch;
   logic [NCH_W-1:0]        r_ch;
   logic [GADDR_WIDTH-1:0]  r_in_base;
   logic [GADDR_WIDTH-1:0]  r_out_base;

   logic                    w_bad_nch;
   logic                    w_last_ch;
   logic                    w_wd_expired;

   assign w_bad_nch = (num_ch == '0) || (num_ch > L_MAX_CH);
   assign w_last_ch = (r_ch == (r_num_ch - 1'b1));

   pool_watchdog #(
      .CNT_W (WD_W)
   ) u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (r_state == ST_IDLE),
      .i_load     (r_state == ST_KICK),
      .i_load_val (WD_LOAD),
      .i_en       (r_state == ST_RUN),
      .o_expired  (w_wd_expired)
   );

   // Job FSM. busy/done/eng_start are registered alongside the state so they
   // line up exactly with IDLE-exit, FIN and KICK respectively.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_kick     <= 1'b0;
         r_err      <= 1'b0;
         r_num_ch   <= '0;
         r_ch       <= '0;
         r_in_base  <= '0;
         r_out_base <= '0;
      end else begin
         r_done <= 1'b0;
         r_kick <= 1'b0;
         if ((r_state != ST_IDLE) && abort) begin
            // Cancel leaves err and the bases as they are.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            unique case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     if (w_bad_nch) begin
                        r_err <= 1'b1;
                     end else begin
                        r_num_ch   <= num_ch;
                        r_ch       <= '0;
                        r_in_base  <= '0;
                        r_out_base <= '0;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_kick     <= 1'b1;
                        r_state    <= ST_KICK;
                     end
                  end
               end
               ST_KICK: begin
                  r_state <= ST_RUN;
               end
               ST_RUN: begin
                  // A finish arriving on the expiry cycle still counts.
                  if (eng_done) begin
                     r_state <= ST_NEXT;
                  end else if (w_wd_expired) begin
                     r_err   <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end
               ST_NEXT: begin
                  if (w_last_ch) begin
                     r_done  <= 1'b1;
                     r_state <= ST_FIN;
                  end else begin
                     r_ch       <= r_ch + 1'b1;
                     r_in_base  <= r_in_base + L_TOTAL;
                     r_out_base <= r_out_base + L_OUT_TOTAL;
                     r_kick     <= 1'b1;
                     r_state    <= ST_KICK;
                  end
               end
               ST_FIN: begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
               default: begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Abort must also kill a kick or a completion pulse in the cycle it arrives.
   assign eng_start = r_kick & ~abort;
   assign done      = r_done & ~abort;
   assign busy      = r_busy;
   assign err       = r_err;

   // Read translation is combinational so the engine sees its usual BRAM
   // read latency.
   assign in_rd_addr  = r_in_base + GADDR_WIDTH'(eng_rd_addr);
   assign out_wr_addr = r_out_base + GADDR_WIDTH'(eng_wr_addr);
   assign out_wr_data = eng_wr_data;
   assign out_wr_en   = eng_wr_en && (r_state == ST_RUN);

   // Host shares the output BRAM read port only while no job runs.
   assign host_rd_gnt = host_rd_req & ~r_busy;
   assign out_rd_addr = host_rd_addr;

endmodule

// File: tb/tb_pool_job_ctrl.sv
module tb_pool_job_ctrl;

   localparam int TIMEOUT = 1023;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, abort, busy, done, err, eng_start, eng_done;
   logic [4:0] num_ch;
   logic [5:0] eng_rd_addr, eng_wr_addr;
   logic       eng_wr_en, out_wr_en, host_rd_req, host_rd_gnt;
   logic [7:0] eng_wr_data, out_wr_data;
   logic [9:0] in_rd_addr, out_wr_addr, host_rd_addr, out_rd_addr;

   pool_job_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .num_ch(num_ch), .abort(abort),
      .busy(busy), .done(done), .err(err), .eng_start(eng_start),
      .eng_done(eng_done), .eng_rd_addr(eng_rd_addr), .eng_wr_en(eng_wr_en),
      .eng_wr_addr(eng_wr_addr), .eng_wr_data(eng_wr_data),
      .in_rd_addr(in_rd_addr), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
      .out_wr_data(out_wr_data), .host_rd_req(host_rd_req),
      .host_rd_addr(host_rd_addr), .host_rd_gnt(host_rd_gnt),
      .out_rd_addr(out_rd_addr)
   );

   // Standard 8x8 test pattern and its 2x2 max-pool result.
   int pat[64] = '{ 2, 34, 18, 23, 45, 11,  8, 27,
                    5, 12, 33,  7, 40,  3, 36,  1,
                   44, 10, 30,  2, 50,  9, 25,  4,
                    3, 20, 14, 29,  1, 48, 17,  6,
                   41,  0, 43, 12,  8, 48, 46, 19,
                   13, 22, 40,  5, 31, 15,  2, 38,
                    9, 14, 50, 21, 33,  7, 44, 10,
                   56, 57, 58, 59, 60, 61, 62, 63};
   int gold0[16] = '{34, 33, 45, 36, 44, 30, 50, 25, 41, 43, 48, 46, 57, 59, 61, 63};

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM models: input BRAM written only by the stimulus process; output
   // BRAM written by the DUT write port, read with one cycle latency.
   logic [7:0] inbram [1024];
   logic [7:0] outbram[1024];
   logic [7:0] rd_q;
   logic       fill_req;
   always @(posedge clk) begin
      if (fill_req) begin
         for (int i = 0; i < 1024; i++) outbram[i] <= 8'hA5;
      end else if (out_wr_en) begin
         outbram[out_wr_addr] <= out_wr_data;
      end
      if (host_rd_gnt) rd_q <= outbram[out_rd_addr];
   end

   typedef struct { int addr; int data; } wr_t;
   wr_t exp_wr[$];
   int  exp_done[$];

   int  n_kick = 0, n_done = 0, job_kicks = 0, last_done_cyc = 0, kick_cyc = 0;
   bit  withhold = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: output pixel o of channel ch is the max of its 2x2 window.
   function automatic int ref_px(input int ch, input int o);
      int r, c, m, v;
      r = o / 4;
      c = o % 4;
      m = 0;
      for (int dr = 0; dr < 2; dr++)
         for (int dc = 0; dc < 2; dc++) begin
            v = int'(inbram[ch*64 + (2*r + dr)*8 + 2*c + dc]);
            if (v > m) m = v;
         end
      return m;
   endfunction

   task automatic push_job(input int n);
      wr_t e;
      for (int ch = 0; ch < n; ch++)
         for (int o = 0; o < 16; o++) begin
            e.addr = ch*16 + o;
            e.data = ref_px(ch, o);
            exp_wr.push_back(e);
         end
   endtask

   // Monitor: pops the scoreboard on every output BRAM write and done pulse.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (out_wr_en === 1'b1) begin
               if (exp_wr.size() == 0) chk("spurious_wr_en", out_wr_en, 0);
               else begin
                  e = exp_wr.pop_front();
                  chk("wr_addr", out_wr_addr, e.addr);
                  chk("wr_data", out_wr_data, e.data);
               end
            end
            if (eng_start === 1'b1) n_kick++;
            if (done === 1'b1) begin
               n_done++;
               if (exp_done.size() == 0) chk("spurious_done", done, 0);
               else begin
                  void'(exp_done.pop_front());
                  chk("done_latency", cyc, last_done_cyc + 2);
               end
            end
         end
      end
   end

   // Stub engine: reads its 64 local pixels through the DUT translation,
   // then writes the 16 window maxima and pulses eng_done.
   logic [7:0] eng_mx[16];
   logic [7:0] eng_px;
   int         eng_ch;
   initial begin
      eng_rd_addr = '0; eng_wr_en = 1'b0; eng_wr_addr = '0; eng_wr_data = '0; eng_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && eng_start === 1'b1) begin
            kick_cyc = cyc;
            if (job_kicks > 0) chk("kick_latency", cyc, last_done_cyc + 2);
            eng_ch = job_kicks;
            job_kicks++;
            if (!withhold) begin
               for (int i = 0; i < 16; i++) eng_mx[i] = 8'd0;
               for (int a = 0; a < 64; a++) begin
                  eng_rd_addr = a[5:0];
                  #1;
                  chk("in_rd_addr", in_rd_addr, eng_ch*64 + a);
                  eng_px = inbram[in_rd_addr];
                  if (eng_px > eng_mx[(a/16)*4 + (a%8)/2]) eng_mx[(a/16)*4 + (a%8)/2] = eng_px;
                  @(negedge clk);
               end
               for (int o = 0; o < 16; o++) begin
                  eng_wr_en = 1'b1; eng_wr_addr = o[5:0]; eng_wr_data = eng_mx[o];
                  @(negedge clk);
               end
               eng_wr_en = 1'b0;
               eng_done = 1'b1;
               last_done_cyc = cyc;
               @(negedge clk);
               eng_done = 1'b0;
            end
         end
      end
   end

   task automatic start_job(input int n);
      job_kicks = 0;
      num_ch = n[4:0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_job(input int n, input bit rand_host, input bit poke);
      int k0, bad_gnt;
      bit seen;
      push_job(n);
      exp_done.push_back(1);
      k0 = n_kick;
      start_job(n);
      chk("busy_after_start", busy, 1);
      chk("kick_after_start", eng_start, 1);
      chk("err_cleared_on_start", err, 0);
      bad_gnt = 0;
      seen = 1'b0;
      for (int i = 0; i < n*120 + 50 && !seen; i++) begin
         if (rand_host) begin
            host_rd_req = 1'($urandom_range(0, 1));
            host_rd_addr = 10'($urandom_range(0, 1023));
         end
         if (poke) begin
            start = (i == 200);
            num_ch = (i == 200) ? 5'd2 : num_ch;
         end
         @(negedge clk);
         if (host_rd_gnt !== 1'b0) bad_gnt++;
         if (done === 1'b1) seen = 1'b1;
      end
      start = 1'b0;
      chk("job_done_seen", seen, 1);
      chk("gnt_while_busy", bad_gnt, 0);
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("gnt_after_done", host_rd_gnt, host_rd_req);
      chk("kicks_per_job", n_kick - k0, n);
      chk("wr_queue_drained", exp_wr.size(), 0);
      chk("err_after_job", err, 0);
   endtask

   task automatic bad_start(input int n);
      int k0;
      k0 = n_kick;
      start_job(n);
      chk("err_bad_nch", err, 1);
      chk("busy_bad_nch", busy, 0);
      repeat (3) @(negedge clk);
      chk("busy_stays_idle", busy, 0);
      chk("no_kick_bad_nch", n_kick - k0, 0);
   endtask

   initial begin
      int idle_cyc, d0, k0, bad, n;
      rst = 1'b1; start = 1'b0; num_ch = '0; abort = 1'b0;
      host_rd_req = 1'b0; host_rd_addr = '0; fill_req = 1'b1;
      for (int i = 0; i < 1024; i++) inbram[i] = 8'd0;
      for (int i = 0; i < 64; i++) inbram[i] = 8'(pat[i]);
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_out_wr_en", out_wr_en, 0);
      chk("rst_host_gnt", host_rd_gnt, 0);
      chk("rst_in_rd_addr", in_rd_addr, 0);
      chk("rst_out_wr_addr", out_wr_addr, 0);
      chk("rst_out_wr_data", out_wr_data, 0);
      fill_req = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // One channel, host read-back held across the job.
      host_rd_req = 1'b1;
      host_rd_addr = 10'd6;
      run_job(1, 1'b0, 1'b0);
      @(negedge clk);
      chk("host_read_addr6", rd_q, gold0[6]);
      host_rd_addr = 10'd5;
      @(negedge clk);
      chk("host_read_addr5", rd_q, gold0[5]);
      host_rd_req = 1'b0;
      for (int i = 0; i < 16; i++) chk($sformatf("out_ch0_%0d", i), outbram[i], gold0[i]);

      // Three channels, a start while busy must be ignored.
      for (int i = 0; i < 64; i++) begin
         inbram[64 + i]  = 8'(pat[i] + 1);
         inbram[128 + i] = 8'($urandom_range(0, 255));
      end
      d0 = n_done;
      run_job(3, 1'b0, 1'b1);
      chk("done_once_3ch", n_done - d0, 1);
      for (int i = 0; i < 16; i++) chk($sformatf("out_ch1_%0d", i), outbram[16 + i], gold0[i] + 1);

      // Illegal channel counts, then a legal start clears err.
      bad_start(0);
      bad_start(17);
      run_job(1, 1'b0, 1'b0);

      // Watchdog: the engine never finishes.
      withhold = 1'b1;
      d0 = n_done;
      start_job(1);
      idle_cyc = -1;
      for (int i = 0; i < TIMEOUT + 50; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            idle_cyc = cyc;
            break;
         end
      end
      chk("wd_idle_cycle", idle_cyc, kick_cyc + TIMEOUT + 1);
      chk("wd_err", err, 1);
      chk("wd_no_done", n_done - d0, 0);
      withhold = 1'b0;
      run_job(1, 1'b0, 1'b0);

      // Abort five cycles into channel 1 of a three-channel job.
      fill_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
      push_job(1);
      d0 = n_done;
      k0 = n_kick;
      start_job(3);
      for (int i = 0; i < 400 && job_kicks < 2; i++) @(negedge clk);
      chk("abort_reached_ch1", job_kicks, 2);
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_err_unchanged", err, 0);
      repeat (120) @(negedge clk);
      bad = 0;
      for (int i = 16; i < 48; i++) if (outbram[i] !== 8'hA5) bad++;
      chk("abort_bram_untouched", bad, 0);
      chk("abort_no_done", n_done - d0, 0);
      chk("abort_kicks", n_kick - k0, 2);
      chk("abort_wr_drained", exp_wr.size(), 0);

      // Random jobs with random data and random host requests.
      repeat (3) begin
         n = $urandom_range(1, 5);
         for (int i = 0; i < n*64; i++) inbram[i] = 8'($urandom_range(0, 255));
         run_job(n, 1'b1, 1'b0);
      end
      host_rd_req = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
